stack_pop_sequencer: RTL and testbench

- Stack-read counterpart of the PUSH/CALL stack-write path. Executes POP rr, RET, RET cc and (optionally) RETI/RETN.
- Issues two byte reads from memory at SP and SP+1, and increments SP after each byte.
- Delivers the 16-bit result to the register file (POP) or the PC (RET family).
- Sits beside the opcode decoder. The decoder pulses start with the decoded op fields, and this block owns the memory bus until done.

---
 rtl/stack_pop_sequencer.sv | 163 ++++++++++++++++
 tb/tb_stack_pop_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_pop_sequencer.sv
// Two-byte stack read for POP rr / RET / RET cc / RETI-RETN: 5 cycles start-to-done at zero wait (RET cc taken 6, not taken 3).
// mem_rd_req is held until mem_rd_ack; start is ignored while busy. STACK_POP_RETI_EN adds the iff_restore pulse on op=11.
module stack_pop_sequencer #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic            CLK,
    input  logic            notRESET,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [1:0]      rr_sel,
    input  logic            cc_true,
    input  logic [AW-1:0]   sp_in,
    output logic            mem_rd_req,
    output logic [AW-1:0]   mem_addr,
    input  logic            mem_rd_ack,
    input  logic [DW-1:0]   mem_rdata,
    output logic [AW-1:0]   sp_out,
    output logic            sp_we,
    output logic            rr_we,
    output logic [1:0]      rr_wsel,
    output logic [2*DW-1:0] rr_wdata,
    output logic            pc_we,
    output logic [AW-1:0]   pc_wdata,
    output logic            iff_restore,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COND  = 3'd1,
        RD_LO = 3'd2,
        RD_HI = 3'd3,
        WB    = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam logic [1:0] OP_POP   = 2'b00;
    localparam logic [1:0] OP_RETCC = 2'b10;
    localparam logic [1:0] OP_RETI  = 2'b11;

    state_t          state;
    logic [1:0]      op_q;
    logic            cc_q;
    logic [AW-1:0]   sp_q;
    logic [DW-1:0]   lo_q;
    logic [AW-1:0]   sp_inc;
    logic            ack;

    assign sp_inc = sp_q + AW'(1);
    // Only acks that answer an outstanding request count.
    assign ack    = mem_rd_ack && mem_rd_req;

    // Outputs are registered: each transition sets up the outputs of the state it enters.
    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            state      <= IDLE;
            op_q       <= '0;
            cc_q       <= 1'b0;
            sp_q       <= '0;
            lo_q       <= '0;
            mem_rd_req <= 1'b0;
            mem_addr   <= '0;
            sp_out     <= '0;
            sp_we      <= 1'b0;
            rr_we      <= 1'b0;
            rr_wsel    <= '0;
            rr_wdata   <= '0;
            pc_we      <= 1'b0;
            pc_wdata   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            sp_we <= 1'b0;
            rr_we <= 1'b0;
            pc_we <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        cc_q    <= cc_true;
                        sp_q    <= sp_in;
                        rr_wsel <= rr_sel;
                        busy    <= 1'b1;
                        if (op == OP_RETCC) begin
                            state <= COND;
                        end else begin
                            state      <= RD_LO;
                            mem_rd_req <= 1'b1;
                            mem_addr   <= sp_in;
                        end
                    end
                end
                COND: begin
                    if (cc_q) begin
                        state      <= RD_LO;
                        mem_rd_req <= 1'b1;
                        mem_addr   <= sp_q;
                    end else begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                RD_LO: begin
                    // Request stays up and moves to SP+1 so the high byte follows without a bubble.
                    if (ack) begin
                        lo_q     <= mem_rdata;
                        sp_q     <= sp_inc;
                        sp_out   <= sp_inc;
                        sp_we    <= 1'b1;
                        mem_addr <= sp_inc;
                        state    <= RD_HI;
                    end
                end
                RD_HI: begin
                    if (ack) begin
                        sp_q       <= sp_inc;
                        sp_out     <= sp_inc;
                        sp_we      <= 1'b1;
                        mem_rd_req <= 1'b0;
                        state      <= WB;
                        if (op_q == OP_POP) begin
                            rr_we    <= 1'b1;
                            rr_wdata <= {mem_rdata, lo_q};
                        end else begin
                            pc_we    <= 1'b1;
                            pc_wdata <= AW'({mem_rdata, lo_q});
                        end
                    end
                end
                WB: begin
                    state <= FIN;
                    done  <= 1'b1;
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    mem_rd_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef STACK_POP_RETI_EN
    // IFF1<=IFF2 fires in the same cycle as the PC write of an op=11 return.
    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            iff_restore <= 1'b0;
        end else begin
            iff_restore <= (state == RD_HI) && ack && (op_q == OP_RETI);
        end
    end
`else
    assign iff_restore = 1'b0;
`endif

endmodule

// File: tb/tb_stack_pop_sequencer.sv
// Scoreboard bench for stack_pop_sequencer: a wait-state memory responder plus expected read/write queues.
module tb_stack_pop_sequencer;

    logic        CLK = 1'b0;
    logic        notRESET = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [1:0]  rr_sel = '0;
    logic        cc_true = 1'b0;
    logic [15:0] sp_in = '0;
    logic        mem_rd_req;
    logic [15:0] mem_addr;
    logic        mem_rd_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic [15:0] sp_out;
    logic        sp_we;
    logic        rr_we;
    logic [1:0]  rr_wsel;
    logic [15:0] rr_wdata;
    logic        pc_we;
    logic [15:0] pc_wdata;
    logic        iff_restore;
    logic        busy;
    logic        done;

    stack_pop_sequencer #(.AW(16), .DW(8)) dut (
        .CLK(CLK), .notRESET(notRESET), .start(start), .op(op), .rr_sel(rr_sel),
        .cc_true(cc_true), .sp_in(sp_in), .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
        .mem_rd_ack(mem_rd_ack), .mem_rdata(mem_rdata), .sp_out(sp_out), .sp_we(sp_we),
        .rr_we(rr_we), .rr_wsel(rr_wsel), .rr_wdata(rr_wdata), .pc_we(pc_we),
        .pc_wdata(pc_wdata), .iff_restore(iff_restore), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wait_n = 0;
    int wcnt = 0;
    logic [15:0] last_addr = '0;
    logic [1:0]  cur_op = '0;
    logic [7:0]  mem [0:65535];

    logic [15:0] exp_addr [$];
    logic [15:0] exp_sp [$];
    logic [15:0] exp_pc [$];
    logic [17:0] exp_rr [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge CLK) cyc++;

    // Memory responder: answers after wait_n idle cycles and checks the address is held meanwhile.
    always @(negedge CLK) begin
        if (notRESET && mem_rd_req) begin
            if (wcnt > 0) check_eq("addr_hold", mem_addr, last_addr);
            last_addr = mem_addr;
            if (wcnt >= wait_n) begin
                mem_rd_ack = 1'b1;
                mem_rdata  = mem[mem_addr];
                wcnt       = 0;
            end else begin
                mem_rd_ack = 1'b0;
                mem_rdata  = 8'h00;
                wcnt++;
            end
        end else begin
            mem_rd_ack = 1'b0;
            wcnt       = 0;
        end
    end

    // Output monitor: every handshake and strobe must match the head of its queue.
    always begin
        @(negedge CLK);
        #1;
        if (notRESET) begin
            if (mem_rd_req && mem_rd_ack) begin
                if (exp_addr.size() == 0) check_eq("rd_unexp", 1, 0);
                else check_eq("rd_addr", mem_addr, exp_addr.pop_front());
            end
            if (sp_we) begin
                if (exp_sp.size() == 0) check_eq("sp_unexp", 1, 0);
                else check_eq("sp_out", sp_out, exp_sp.pop_front());
            end
            if (rr_we) begin
                if (exp_rr.size() == 0) check_eq("rr_unexp", 1, 0);
                else check_eq("rr_wr", {rr_wsel, rr_wdata}, exp_rr.pop_front());
            end
            if (pc_we) begin
                if (exp_pc.size() == 0) check_eq("pc_unexp", 1, 0);
                else check_eq("pc_wr", pc_wdata, exp_pc.pop_front());
            end
            if (pc_we || iff_restore) begin
`ifdef STACK_POP_RETI_EN
                check_eq("iff", iff_restore, pc_we && (cur_op == 2'b11));
`else
                check_eq("iff", iff_restore, 0);
`endif
            end
        end
    end

    function automatic int q_left();
        return exp_addr.size() + exp_sp.size() + exp_pc.size() + exp_rr.size();
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_out"},
                 {busy, done, mem_rd_req, sp_we, rr_we, pc_we, iff_restore, rr_wsel}, 0);
        check_eq({tag, "_addr"}, mem_addr, 0);
        check_eq({tag, "_spo"}, sp_out, 0);
        check_eq({tag, "_data"}, {rr_wdata, pc_wdata}, 0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [1:0] r, input logic c,
                          input logic [15:0] sp, input int w, input bit disturb);
        int lat;
        int s;
        int d;
        bit taken;
        logic [15:0] sp1;
        logic [15:0] sp2;
        logic [15:0] res;
        wait_n = w;
        cur_op = o;
        taken  = (o != 2'b10) || c;
        sp1    = sp + 16'd1;
        sp2    = sp1 + 16'd1;
        res    = {mem[sp1], mem[sp]};
        if (taken) begin
            exp_addr.push_back(sp);
            exp_addr.push_back(sp1);
            exp_sp.push_back(sp1);
            exp_sp.push_back(sp2);
            if (o == 2'b00) exp_rr.push_back({r, res});
            else exp_pc.push_back(res);
            lat = ((o == 2'b10) ? 6 : 5) + 2 * w;
        end else begin
            lat = 3;
        end
        @(negedge CLK);
        op = o; rr_sel = r; cc_true = c; sp_in = sp; start = 1'b1;
        s = cyc;
        d = -1;
        for (int i = 0; i < 100 && d < 0; i++) begin
            @(negedge CLK);
            start = disturb && busy && ((i % 2) == 0);
            if (disturb) begin
                op    = 2'($urandom_range(0, 3));
                sp_in = 16'($urandom);
            end
            #2;
            if (done) d = cyc;
        end
        start = 1'b0;
        if (d < 0) check_eq("timeout", 1, 0);
        else check_eq("latency", d - s + 1, lat);
        @(negedge CLK);
        #2;
        check_eq("done_pulse", {done, busy}, 0);
        check_eq("q_left", q_left(), 0);
    endtask

    task automatic reset_mid_op();
        bit seen = 0;
        wait_n = 2;
        cur_op = 2'b00;
        mem[16'h3000] = 8'h77;
        mem[16'h3001] = 8'h66;
        exp_addr.push_back(16'h3000);
        exp_sp.push_back(16'h3001);
        @(negedge CLK);
        op = 2'b00; rr_sel = 2'b10; cc_true = 1'b0; sp_in = 16'h3000; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            #2;
            if (sp_we) seen = 1;
            else @(negedge CLK);
        end
        check_eq("rst_reach_hi", seen, 1);
        notRESET = 1'b0;
        #1;
        check_all_zero("rst_mid");
        repeat (2) @(negedge CLK);
        #2;
        check_all_zero("rst_hold");
        notRESET = 1'b1;
        @(negedge CLK);
        #2;
        check_eq("rst_after_busy", busy, 0);
        check_eq("rst_q_left", q_left(), 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1000] = 8'h34; mem[16'h1001] = 8'h12;
        mem[16'h2000] = 8'h99; mem[16'h2001] = 8'h88;
        mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB;
        mem[16'h4000] = 8'h21; mem[16'h4001] = 8'h43;
        mem[16'h5000] = 8'h5A; mem[16'h5001] = 8'hA5;
        mem[16'h6000] = 8'hD7; mem[16'h6001] = 8'h3C;

        #2 notRESET = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge CLK);
        notRESET = 1'b1;

        run_op(2'b00, 2'b01, 1'b0, 16'h1000, 0, 0);   // POP DE
        run_op(2'b10, 2'b00, 1'b0, 16'h2000, 0, 0);   // RET cc not taken
        run_op(2'b01, 2'b00, 1'b0, 16'hFFFF, 0, 0);   // RET wrapping SP
        check_eq("sp_final", sp_out, 16'h0001);
        run_op(2'b10, 2'b00, 1'b1, 16'h4000, 3, 1);   // RET cc taken, waits, stray starts
        reset_mid_op();
        run_op(2'b00, 2'b11, 1'b0, 16'h1000, 0, 0);   // POP AF after reset
        run_op(2'b11, 2'b00, 1'b0, 16'h5000, 0, 0);   // RETI/RETN
        run_op(2'b00, 2'b11, 1'b0, 16'h6000, 1, 0);   // POP AF, one wait
        run_op(2'b01, 2'b00, 1'b1, 16'h2000, 2, 1);   // RET with waits and stray starts

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
